can_reg_write_arbiter: RTL and testbench

//  Sequences and shares the single write path into the CAN controller register bank
//  (bank of synchronous-reset, write-enabled registers) between two requesters:

---
 rtl/can_reg_write_arbiter.sv | 99 +++++++++
 tb/tb_can_reg_write_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_reg_write_arbiter.sv
// can_reg_write_arbiter: shares the CAN register-bank write port between host and core requesters.
// Define CAN_WR_PARITY_EN to add the wr_par even-parity output alongside reg_wdata.
module can_reg_write_arbiter #(
    parameter int NUM_REGS   = 32,
    parameter int AW         = 5,
    parameter int DW         = 8,
    parameter int LOCK_LIMIT = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_sync,
    input  logic                reset_mode,
    input  logic                host_req,
    input  logic [AW-1:0]       host_addr,
    input  logic [DW-1:0]       host_data,
    output logic                host_ack,
    output logic                host_err,
    input  logic                core_req,
    input  logic [AW-1:0]       core_addr,
    input  logic [DW-1:0]       core_data,
    output logic                core_ack,
    output logic [NUM_REGS-1:0] reg_we,
    output logic [DW-1:0]       reg_wdata,
    output logic                busy
`ifdef CAN_WR_PARITY_EN
    ,
    output logic                wr_par
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          host_q;
    logic          rej_q;
    logic [SW-1:0] starve_cnt;
    logic          grant;
    logic          host_win;
    logic [AW-1:0] sel_addr;
    logic          sel_rej;
    logic          win_req;

    always_comb begin
        grant     = state == IDLE && (host_req || core_req);
        host_win  = host_req && (!core_req || starve_cnt == SW'(STARVE_MAX));
        sel_addr  = host_win ? host_addr : core_addr;
        // core updates bypass the reset-mode lock, only range is enforced
        sel_rej   = 32'(sel_addr) >= NUM_REGS ||
                    (host_win && 32'(sel_addr) < LOCK_LIMIT && !reset_mode);
        win_req   = host_q ? host_req : core_req;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? WRITE : IDLE;
            WRITE:   state_nxt = ACK;
            ACK:     state_nxt = win_req ? ACK : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            host_q     <= 1'b0;
            rej_q      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                addr_q <= sel_addr;
                data_q <= host_win ? host_data : core_data;
                host_q <= host_win;
                rej_q  <= sel_rej;
                if (host_win)
                    starve_cnt <= '0;
                else if (host_req && starve_cnt != SW'(STARVE_MAX))
                    starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        reg_we    = (state == WRITE && !rej_q) ? NUM_REGS'(1) << addr_q : '0;
        reg_wdata = (state == WRITE && !rej_q) ? data_q : '0;
        host_ack  = state == ACK && host_q;
        host_err  = state == ACK && host_q && rej_q;
        core_ack  = state == ACK && !host_q;
        busy      = state != IDLE;
    end

`ifdef CAN_WR_PARITY_EN
    assign wr_par = ^reg_wdata;
`endif

endmodule

// File: tb/tb_can_reg_write_arbiter.sv
// tb_can_reg_write_arbiter: directed scoreboard bench for can_reg_write_arbiter.
module tb_can_reg_write_arbiter;
    localparam int NR = 32;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_sync = 1'b1;
    logic          reset_mode = 1'b0;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_ack;
    logic          host_err;
    logic          core_req = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_data = '0;
    logic          core_ack;
    logic [NR-1:0] reg_we;
    logic [DW-1:0] reg_wdata;
    logic          busy;
`ifdef CAN_WR_PARITY_EN
    logic          wr_par;
    logic          prev_par = 1'b0;
`endif

    always #5 clk = ~clk;

    can_reg_write_arbiter #(.NUM_REGS(NR), .AW(AW), .DW(DW), .LOCK_LIMIT(8), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_sync(rst_sync), .reset_mode(reset_mode),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .host_err(host_err),
        .core_req(core_req), .core_addr(core_addr), .core_data(core_data),
        .core_ack(core_ack), .reg_we(reg_we), .reg_wdata(reg_wdata), .busy(busy)
`ifdef CAN_WR_PARITY_EN
        , .wr_par(wr_par)
`endif
    );

    typedef struct {
        logic          host;
        logic [NR-1:0] we;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            passed = 0;
    int            total = 0;
    logic          hack_q = 1'b0;
    logic          cack_q = 1'b0;
    logic [NR-1:0] prev_we = '0;
    logic [DW-1:0] prev_wdata = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endfunction

    function automatic void push(logic host, int addr, logic [DW-1:0] data, logic wr, logic err);
        exp_t e;
        e.host = host;
        e.we   = wr ? NR'(1) << addr : '0;
        e.data = wr ? data : '0;
        e.err  = err;
        sb.push_back(e);
    endfunction

    // an ack rising edge closes a transfer; the previous cycle was its WRITE cycle
    always @(negedge clk) begin
        if ((host_ack && !hack_q) || (core_ack && !cack_q)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("who", host_ack, mon_e.host);
                chk("we", prev_we, mon_e.we);
                chk("wdata", prev_wdata, mon_e.data);
                chk("host_err", host_err, mon_e.err);
`ifdef CAN_WR_PARITY_EN
                chk("wr_par", prev_par, ^mon_e.data);
`endif
            end
        end
        if (reg_we != '0)
            chk("onehot", $countones(reg_we), 1);
        hack_q     <= host_ack;
        cack_q     <= core_ack;
        prev_we    <= reg_we;
        prev_wdata <= reg_wdata;
`ifdef CAN_WR_PARITY_EN
        prev_par   <= wr_par;
`endif
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        host_addr = a;
        host_data = d;
        host_req  = 1'b1;
        while (!host_ack && n < 100) begin @(negedge clk); n++; end
        chk("host_ack_seen", host_ack, 1);
        host_req = 1'b0;
        n = 0;
        while (host_ack && n < 10) begin @(negedge clk); n++; end
        chk("host_ack_drop", host_ack, 0);
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        core_addr = a;
        core_data = d;
        core_req  = 1'b1;
        while (!core_ack && n < 100) begin @(negedge clk); n++; end
        chk("core_ack_seen", core_ack, 1);
        core_req = 1'b0;
        n = 0;
        while (core_ack && n < 10) begin @(negedge clk); n++; end
        chk("core_ack_drop", core_ack, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_we", reg_we, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_hack", host_ack, 0);
        chk("rst_herr", host_err, 0);
        chk("rst_cack", core_ack, 0);
        chk("rst_busy", busy, 0);
        rst_sync = 1'b0;
        @(negedge clk);
        // T1: exact latency of a plain host write
        push(1, 10, 8'h5A, 1, 0);
        host_addr = 6'd10;
        host_data = 8'h5A;
        host_req  = 1'b1;
        @(negedge clk);
        chk("t1_we", reg_we, 32'h0000_0400);
        chk("t1_wdata", reg_wdata, 8'h5A);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_ack", host_ack, 1);
        chk("t1_err", host_err, 0);
        chk("t1_we_off", reg_we, 0);
        @(negedge clk);
        chk("t1_ack_hold", host_ack, 1);
        host_req = 1'b0;
        @(negedge clk);
        chk("t1_ack_drop", host_ack, 0);
        chk("t1_idle", busy, 0);
        // T2: lock window and its boundaries
        reset_mode = 1'b0;
        push(1, 3, 8'h33, 0, 1);  host_write(6'd3, 8'h33);
        push(0, 3, 8'h44, 1, 0);  core_write(6'd3, 8'h44);
        push(1, 7, 8'h77, 0, 1);  host_write(6'd7, 8'h77);
        push(1, 8, 8'h88, 1, 0);  host_write(6'd8, 8'h88);
        push(1, 31, 8'h31, 1, 0); host_write(6'd31, 8'h31);
        reset_mode = 1'b1;
        push(1, 3, 8'h33, 1, 0);  host_write(6'd3, 8'h33);
        // reset_mode dropping after the latch must not reject the write
        push(1, 2, 8'h22, 1, 0);
        fork
            host_write(6'd2, 8'h22);
            begin @(negedge clk); reset_mode = 1'b0; end
        join
        // T4: out-of-range addresses
        push(1, 40, 8'h40, 0, 1); host_write(6'd40, 8'h40);
        push(1, 32, 8'h32, 0, 1); host_write(6'd32, 8'h32);
        push(0, 40, 8'h41, 0, 0); core_write(6'd40, 8'h41);
        // T3: core wins four times, then host is forced through
        for (int i = 0; i < 4; i++) push(0, 16 + i, 8'h10 + 8'(i), 1, 0);
        push(1, 9, 8'hA5, 1, 0);
        push(0, 20, 8'h14, 1, 0);
        fork
            host_write(6'd9, 8'hA5);
            for (int i = 0; i < 5; i++) core_write(6'(16 + i), 8'h10 + 8'(i));
        join
        // starve counter was cleared, so core wins the next tie again
        push(0, 22, 8'h22, 1, 0);
        push(1, 11, 8'h11, 1, 0);
        fork
            host_write(6'd11, 8'h11);
            core_write(6'd22, 8'h22);
        join
        // T5: reset during WRITE, pending host request re-granted afterwards
        push(1, 12, 8'hC3, 1, 0);
        fork
            host_write(6'd12, 8'hC3);
            begin : inj
                int n;
                n = 0;
                while (reg_we == '0 && n < 20) begin @(negedge clk); n++; end
                chk("t5_in_write", reg_we, 32'h0000_1000);
                rst_sync = 1'b1;
                @(negedge clk);
                chk("t5_we", reg_we, 0);
                chk("t5_wdata", reg_wdata, 0);
                chk("t5_hack", host_ack, 0);
                chk("t5_cack", core_ack, 0);
                chk("t5_busy", busy, 0);
                rst_sync = 1'b0;
            end
        join
        // T6: parity-relevant core data
        push(0, 20, 8'h07, 1, 0); core_write(6'd20, 8'h07);
        push(0, 21, 8'h03, 1, 0); core_write(6'd21, 8'h03);
        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
